six_bit_counter: RTL and testbench

- Free-running 6-bit synchronous binary up-counter.
- Built from six toggle (T) flip-flop stages.
- Each count bit is exposed as a separate 1-bit output, q0 (LSB) through q5 (MSB).
- Used as a small timing/sequence source and as a reference block for flip-flop-level counter construction.

---
 rtl/six_bit_counter_pkg.sv | 21 ++
 rtl/six_bit_counter_if.sv | 22 ++
 rtl/six_bit_counter_t_flip_flop.sv | 22 ++
 rtl/six_bit_counter.sv | 47 ++++
 tb/tb_six_bit_counter.sv | 131 +++++++++++++
 5 files changed

// File: rtl/six_bit_counter_pkg.sv
// six_bit_counter_pkg
//   Shared constants for the six-bit counter and its consumers.
//   COUNT_WIDTH : number of count stages (fixed at 6)
//   COUNT_MAX   : terminal count value before wrap (63)
//   pack_count  : helper that packs the discrete q0..q5 bits into a vector
package six_bit_counter_pkg;

    localparam int unsigned COUNT_WIDTH = 6;
    localparam int unsigned COUNT_MAX   = (1 << COUNT_WIDTH) - 1;

    typedef logic [COUNT_WIDTH-1:0] count_t;

    // q5 is the MSB, q0 the LSB.
    function automatic count_t pack_count(
        input logic q0, input logic q1, input logic q2,
        input logic q3, input logic q4, input logic q5
    );
        return {q5, q4, q3, q2, q1, q0};
    endfunction

endpackage

// File: rtl/six_bit_counter_if.sv
// six_bit_counter_if
//   Bundle of the six discrete count bits, for consumers that want to pass
//   the counter outputs around as one object.
//   master : driven by the counter side (q0..q5 outputs)
//   slave  : observed by consumers (q0..q5 inputs, plus packed count)
interface six_bit_counter_if;
    import six_bit_counter_pkg::*;

    logic q0;
    logic q1;
    logic q2;
    logic q3;
    logic q4;
    logic q5;

    count_t count;
    assign count = pack_count(q0, q1, q2, q3, q4, q5);

    modport master (output q0, q1, q2, q3, q4, q5);
    modport slave  (input  q0, q1, q2, q3, q4, q5, count);

endinterface

// File: rtl/six_bit_counter_t_flip_flop.sv
// t_flip_flop
//   Single toggle flip-flop stage with synchronous active-low reset.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears q
//   t     : toggle enable; q inverts on the edge when set, holds otherwise
//   q     : registered output
module t_flip_flop (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/six_bit_counter.sv
// six_bit_counter
//   Free-running 6-bit synchronous binary up-counter built from six T
//   flip-flop stages sharing one clock. Wraps 63 -> 0.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears the count
//   q0..q5: registered count bits, q0 = LSB, q5 = MSB
module six_bit_counter
    import six_bit_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output logic q0,
    output logic q1,
    output logic q2,
    output logic q3,
    output logic q4,
    output logic q5
);

    count_t q;
    count_t t;

    // Stage i toggles only when every lower stage is 1 (carry chain).
    assign t[0] = 1'b1;
    always_comb begin
        for (int unsigned i = 1; i < COUNT_WIDTH; i++) begin
            t[i] = t[i-1] & q[i-1];
        end
    end

    for (genvar g = 0; g < COUNT_WIDTH; g++) begin : g_stage
        t_flip_flop u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (t[g]),
            .q     (q[g])
        );
    end

    assign q0 = q[0];
    assign q1 = q[1];
    assign q2 = q[2];
    assign q3 = q[3];
    assign q4 = q[4];
    assign q5 = q[5];

endmodule

// File: tb/tb_six_bit_counter.sv
// tb_six_bit_counter
//   Directed self-checking bench for six_bit_counter.
module tb_six_bit_counter;
    import six_bit_counter_pkg::*;

    logic clk;
    logic reset;

    six_bit_counter_if cif ();

    six_bit_counter dut (
        .clk   (clk),
        .reset (reset),
        .q0    (cif.q0),
        .q1    (cif.q1),
        .q2    (cif.q2),
        .q3    (cif.q3),
        .q4    (cif.q4),
        .q5    (cif.q5)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b (%0d), expected %b (%0d)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] cnt();
        return cif.count;
    endfunction

    logic [5:0] exp_cnt;
    logic [5:0] prev;

    initial begin
        // Reset held for 3 edges from power-up.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", cnt(), 6'd0);
        end

        // Release and count 10 edges, +1 each edge.
        reset = 1'b1;
        exp_cnt = 6'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_cnt = exp_cnt + 6'd1;
            check("count_up", cnt(), exp_cnt);
        end
        check("count_10", cnt(), 6'b001010);

        // Full wrap: 63 edges -> 63, 64th -> 0, 65th -> 1.
        reset = 1'b0;
        tick();
        check("reset_midrun", cnt(), 6'd0);
        reset = 1'b1;
        for (int i = 0; i < 63; i++) tick();
        check("reach_63", cnt(), 6'b111111);
        tick();
        check("wrap_0", cnt(), 6'b000000);
        tick();
        check("wrap_1", cnt(), 6'b000001);

        // Count to 37, assert reset between edges.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 37; i++) tick();
        check("reach_37", cnt(), 6'b100101);
        reset = 1'b0;
        #2;
        check("no_async_reset", cnt(), 6'b100101);
        tick();
        check("sync_reset_37", cnt(), 6'b000000);
        reset = 1'b1;
        tick();
        check("release_1", cnt(), 6'b000001);

        // Reset exactly at 63 must not wrap-increment.
        for (int i = 0; i < 62; i++) tick();
        check("reach_63b", cnt(), 6'b111111);
        reset = 1'b0;
        tick();
        check("reset_at_63", cnt(), 6'b000000);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) tick();
        check("count_32", cnt(), 6'b100000);
        check("q5_set", {5'd0, cif.q5}, 6'd1);

        // 128 edges: value and toggle mask per edge.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_cnt = 6'd0;
        for (int i = 0; i < 128; i++) begin
            prev = cnt();
            tick();
            check("run128_val", cnt(), exp_cnt + 6'd1);
            check("run128_tgl", prev ^ cnt(), exp_cnt ^ (exp_cnt + 6'd1));
            exp_cnt = exp_cnt + 6'd1;
            if (i == 31) check("all_toggle_31_32", prev ^ cnt(), 6'b111111);
            if (i == 1)  check("q1_toggle_at_2", prev ^ cnt(), 6'b000011);
        end
        check("run128_end", cnt(), 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
